// File: rtl/axil_pkg.sv
// Shared types for the queued AXI4-Lite master: FSM states, AXI response
// codes and the command record stored in the command queue.
package axil_pkg;

    // Default widths used by the reference command record.
    localparam int AXIL_ADDR_W = 32;
    localparam int AXIL_DATA_W = 32;
    localparam int AXIL_STRB_W = AXIL_DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP_OUT = 3'd5
    } fsm_state_e;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_e;

    // One queued command. The top module declares a layout-identical record
    // sized by its own parameters and hands it to the FIFO as a type parameter.
    typedef struct packed {
        logic                   write;
        logic [AXIL_ADDR_W-1:0] addr;
        logic [AXIL_DATA_W-1:0] wdata;
        logic [AXIL_STRB_W-1:0] wstrb;
    } axil_cmd_t;

    // States in which the master is waiting on the slave; the watchdog runs here.
    function automatic logic is_wait_state(input fsm_state_e s);
        return (s == WR_REQ) || (s == WR_RESP) || (s == RD_REQ) || (s == RD_RESP);
    endfunction

endpackage

// File: rtl/axil_cmd_fifo.sv
// Synchronous in-order command queue. Push is ignored when full and pop is
// ignored when empty, so the occupancy count can never over- or underflow.
module axil_cmd_fifo
    import axil_pkg::*;
#(
    parameter type entry_t = axil_cmd_t,
    parameter int  DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    // Entry storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axil_master_queue.sv
// Queued AXI4-Lite master. Commands enter an in-order queue; each one is run
// as a single AXI4-Lite read or write with exactly one transaction in flight,
// and its result is presented on the response port before the next pop.
//
// Handshakes: every valid/ready pair on this block transfers on a rising edge
// where both are high; a valid, once raised, is held with its payload stable
// until that edge, and is never withdrawn early.
module axil_master_queue
    import axil_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                   aclk,
    input  logic                   areset,
    // command port
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [DATA_W-1:0]      cmd_wdata,
    input  logic [DATA_W/8-1:0]    cmd_wstrb,
    // response port
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_write,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic [1:0]             rsp_resp,
    // AXI4-Lite write address
    output logic [ADDR_W-1:0]      awaddr,
    output logic [2:0]             awprot,
    output logic                   awvalid,
    input  logic                   awready,
    // AXI4-Lite write data
    output logic [DATA_W-1:0]      wdata,
    output logic [DATA_W/8-1:0]    wstrb,
    output logic                   wvalid,
    input  logic                   wready,
    // AXI4-Lite write response
    input  logic [1:0]             bresp,
    input  logic                   bvalid,
    output logic                   bready,
    // AXI4-Lite read address
    output logic [ADDR_W-1:0]      araddr,
    output logic [2:0]             arprot,
    output logic                   arvalid,
    input  logic                   arready,
    // AXI4-Lite read data
    input  logic [DATA_W-1:0]      rdata,
    input  logic [1:0]             rresp,
    input  logic                   rvalid,
    output logic                   rready,
    // status
    output logic [$clog2(DEPTH):0] cmd_count,
    output logic                   busy,
    output logic                   timeout,
    output fsm_state_e             fsm_state
);

    localparam int STRB_W = DATA_W / 8;
    localparam int WD_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } cmd_t;

    fsm_state_e      state;
    cmd_t            push_entry;
    cmd_t            head;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            ready_en;
    logic            aw_pend;
    logic            w_pend;
    logic            ar_pend;
    logic            aw_left;
    logic            w_left;
    logic            ar_left;
    axi_resp_e       resp_q;
    logic [WD_W-1:0] wait_cnt;

    // ready_en keeps cmd_ready low while in reset without looking at areset.
    assign cmd_ready  = ready_en & ~fifo_full;
    assign fifo_push  = cmd_valid & cmd_ready;
    assign fifo_pop   = (state == IDLE) & ~fifo_empty & ~rsp_valid;
    assign push_entry = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, wstrb: cmd_wstrb};

    // A request channel is still outstanding if it was not handshaken this cycle.
    assign aw_left = aw_pend & ~(awvalid & awready);
    assign w_left  = w_pend  & ~(wvalid  & wready);
    assign ar_left = ar_pend & ~(arvalid & arready);

    assign awprot    = 3'b000;
    assign arprot    = 3'b000;
    assign rsp_resp  = resp_q;
    assign busy      = (state != IDLE) | ~fifo_empty;
    assign fsm_state = state;

    axil_cmd_fifo #(
        .entry_t (cmd_t),
        .DEPTH   (DEPTH)
    ) u_cmd_fifo (
        .clk       (aclk),
        .rst       (areset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (cmd_count)
    );

    // Transaction sequencer with registered AXI/response outputs and watchdog.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= IDLE;
            ready_en  <= 1'b0;
            awaddr    <= '0;
            awvalid   <= 1'b0;
            wdata     <= '0;
            wstrb     <= '0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            araddr    <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            aw_pend   <= 1'b0;
            w_pend    <= 1'b0;
            ar_pend   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            resp_q    <= OKAY;
            wait_cnt  <= '0;
            timeout   <= 1'b0;
        end else begin
            ready_en <= 1'b1;

            // Watchdog: count cycles in a wait state, saturate, flag once.
            // Entering a wait state below overrides the increment with zero.
            if (is_wait_state(state)) begin
                if (wait_cnt != WD_LIMIT) begin
                    wait_cnt <= wait_cnt + WD_W'(1);
                end
                if ((TIMEOUT_CYC != 0) && ((wait_cnt + WD_W'(1)) == WD_LIMIT)) begin
                    timeout <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        wait_cnt <= '0;
                        if (head.write) begin
                            awaddr  <= head.addr;
                            wdata   <= head.wdata;
                            wstrb   <= head.wstrb;
                            aw_pend <= 1'b1;
                            w_pend  <= 1'b1;
                            state   <= WR_REQ;
                        end else begin
                            araddr  <= head.addr;
                            ar_pend <= 1'b1;
                            state   <= RD_REQ;
                        end
                    end
                end

                WR_REQ: begin
                    // Address and data complete independently, in any order.
                    aw_pend <= aw_left;
                    w_pend  <= w_left;
                    awvalid <= aw_left;
                    wvalid  <= w_left;
                    if (!aw_left && !w_left) begin
                        bready   <= 1'b1;
                        wait_cnt <= '0;
                        state    <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        resp_q    <= axi_resp_e'(bresp);
                        rsp_write <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RSP_OUT;
                    end
                end

                RD_REQ: begin
                    ar_pend <= ar_left;
                    arvalid <= ar_left;
                    if (!ar_left) begin
                        rready   <= 1'b1;
                        wait_cnt <= '0;
                        state    <= RD_RESP;
                    end
                end

                RD_RESP: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        resp_q    <= axi_resp_e'(rresp);
                        rsp_write <= 1'b0;
                        rsp_rdata <= rdata;
                        rsp_valid <= 1'b1;
                        state     <= RSP_OUT;
                    end
                end

                RSP_OUT: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_master_queue.sv
// Directed bench for axil_master_queue: reactive AXI4-Lite slave with
// per-channel wait knobs, response scoreboard, and hand-computed checks.
module tb_axil_master_queue;
    import axil_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int DEPTH  = 4;
    localparam int TMO    = 8;

    logic              aclk;
    logic              areset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_resp;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [2:0]        cmd_count;
    logic              busy;
    logic              timeout;
    fsm_state_e        fsm_state;

    axil_master_queue #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .awaddr    (awaddr),
        .awprot    (awprot),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .araddr    (araddr),
        .arprot    (arprot),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rvalid    (rvalid),
        .rready    (rready),
        .cmd_count (cmd_count),
        .busy      (busy),
        .timeout   (timeout),
        .fsm_state (fsm_state)
    );

    // ---------------- clock ----------------
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // ---------------- checking ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rsp_word(input logic w, input logic [1:0] r, input logic [31:0] d);
        return {29'd0, w, r, d};
    endfunction

    // ---------------- slave knobs ----------------
    int          aw_wait = 0;
    int          w_wait  = 0;
    int          ar_wait = 0;
    int          b_wait  = 0;
    int          r_wait  = 0;
    logic        stall      = 1'b0;
    logic        r_from_adr = 1'b0;
    logic [1:0]  b_resp_k   = 2'd0;
    logic [1:0]  r_resp_k   = 2'd0;
    logic [31:0] r_data_k   = 32'd0;

    // Reactive slave: readies/valids change on the falling edge only.
    initial begin
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        logic [31:0] ar_lat;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0; ar_lat = '0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; bresp = 2'd0; rvalid = 1'b0; rresp = 2'd0; rdata = '0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                awready = 1'b0; wready = 1'b0; arready = 1'b0;
                bvalid = 1'b0; rvalid = 1'b0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            end else begin
                if (awvalid && !stall) begin
                    if (aw_cnt >= aw_wait) awready = 1'b1;
                    else begin awready = 1'b0; aw_cnt++; end
                end else begin awready = 1'b0; aw_cnt = 0; end

                if (wvalid && !stall) begin
                    if (w_cnt >= w_wait) wready = 1'b1;
                    else begin wready = 1'b0; w_cnt++; end
                end else begin wready = 1'b0; w_cnt = 0; end

                if (arvalid && !stall) begin
                    if (ar_cnt >= ar_wait) begin arready = 1'b1; ar_lat = araddr; end
                    else begin arready = 1'b0; ar_cnt++; end
                end else begin arready = 1'b0; ar_cnt = 0; end

                if (bready && !stall) begin
                    if (b_cnt >= b_wait) begin bvalid = 1'b1; bresp = b_resp_k; end
                    else begin bvalid = 1'b0; b_cnt++; end
                end else begin bvalid = 1'b0; b_cnt = 0; end

                if (rready && !stall) begin
                    if (r_cnt >= r_wait) begin
                        rvalid = 1'b1;
                        rresp  = r_resp_k;
                        rdata  = r_from_adr ? {16'hC0DE, ar_lat[15:0]} : r_data_k;
                    end else begin rvalid = 1'b0; r_cnt++; end
                end else begin rvalid = 1'b0; r_cnt = 0; end
            end
        end
    end

    // Response monitor: one record per falling edge that precedes a handshake.
    initial begin
        logic [63:0] exp_w;
        forever begin
            @(negedge aclk);
            if (!areset && rsp_valid && rsp_ready) begin
                check_val("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_w = exp_q.pop_front();
                    check_val("rsp_word", rsp_word(rsp_write, rsp_resp, rsp_rdata), exp_w);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int g = 0;
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        while (!cmd_ready && g < 200) begin
            @(negedge aclk);
            g++;
        end
        check_val("push_accept", 64'(cmd_ready), 64'd1);
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    // sel: 0 = awvalid, 1 = arvalid, 2 = bready, 3 = rsp_valid
    task automatic wait_sig(input string tag, input int sel);
        int   g = 0;
        logic s;
        s = 1'b0;
        while (g < 200) begin
            case (sel)
                0:       s = awvalid;
                1:       s = arvalid;
                2:       s = bready;
                default: s = rsp_valid;
            endcase
            if (s) break;
            @(negedge aclk);
            g++;
        end
        check_val(tag, 64'(s), 64'd1);
    endtask

    task automatic wait_drain(input string tag);
        int g = 0;
        while ((exp_q.size() != 0 || busy) && g < 500) begin
            @(negedge aclk);
            g++;
        end
        check_val(tag, 64'(exp_q.size() == 0 && !busy), 64'd1);
    endtask

    // ---------------- global time limit ----------------
    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    // ---------------- directed sequence ----------------
    initial begin
        areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge aclk);

        // reset state
        check_val("rst_valids", {57'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}, 64'd0);
        check_val("rst_count", 64'(cmd_count), 64'd0);
        check_val("rst_busy_tmo", {62'd0, busy, timeout}, 64'd0);
        check_val("rst_prot", {58'd0, awprot, arprot}, 64'd0);
        check_val("rst_rsp", rsp_word(rsp_write, rsp_resp, rsp_rdata), 64'd0);
        check_val("rst_state", 64'(fsm_state), 64'(IDLE));
        areset = 1'b0;
        @(negedge aclk);
        check_val("ready_after_rst", 64'(cmd_ready), 64'd1);

        // T1: simple write, latency of first AXI valid
        exp_q.push_back(rsp_word(1'b1, 2'd0, 32'h0));
        push_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        check_val("t1_aw_edge1", 64'(awvalid), 64'd0);
        @(negedge aclk);
        check_val("t1_aw_edge2", 64'(awvalid), 64'd0);
        check_val("t1_state_wrreq", 64'(fsm_state), 64'(WR_REQ));
        @(negedge aclk);
        check_val("t1_aw_edge3", {62'd0, awvalid, wvalid}, 64'd3);
        check_val("t1_awaddr", 64'(awaddr), 64'h10);
        check_val("t1_wdata", 64'(wdata), 64'hDEADBEEF);
        check_val("t1_wstrb", 64'(wstrb), 64'hF);
        wait_drain("t1_drain");

        // T2: read with 3 wait cycles, response held under back-pressure
        r_wait = 3; r_data_k = 32'hDEADBEEF; r_resp_k = 2'd0; rsp_ready = 1'b0;
        exp_q.push_back(rsp_word(1'b0, 2'd0, 32'hDEADBEEF));
        push_cmd(1'b0, 32'h10, 32'h0, 4'h0);
        wait_sig("t2_arvalid", 1);
        check_val("t2_araddr", 64'(araddr), 64'h10);
        wait_sig("t2_rsp_valid", 3);
        repeat (3) @(negedge aclk);
        check_val("t2_rsp_hold", 64'(rsp_valid), 64'd1);
        check_val("t2_rsp_stable", 64'(rsp_rdata), 64'hDEADBEEF);
        @(posedge aclk);
        #1 rsp_ready = 1'b1;
        wait_drain("t2_drain");
        check_val("t2_no_timeout", 64'(timeout), 64'd0);
        r_wait = 0;

        // T3: wready two cycles before awready, SLVERR forwarded
        aw_wait = 2; w_wait = 0; b_resp_k = 2'd2;
        exp_q.push_back(rsp_word(1'b1, 2'd2, 32'h0));
        push_cmd(1'b1, 32'h20, 32'h12345678, 4'h3);
        wait_sig("t4_awvalid", 0);
        check_val("t4_both_up", {62'd0, awvalid, wvalid}, 64'd3);
        check_val("t4_wstrb", 64'(wstrb), 64'h3);
        @(negedge aclk);
        check_val("t4_w_first", {62'd0, awvalid, wvalid}, 64'd2);
        @(negedge aclk);
        check_val("t4_aw_hold", {62'd0, awvalid, wvalid}, 64'd2);
        check_val("t4_awaddr_stable", 64'(awaddr), 64'h20);
        @(negedge aclk);
        check_val("t4_aw_done", 64'(awvalid), 64'd0);
        wait_drain("t4_drain");
        aw_wait = 0; b_resp_k = 2'd0;

        // T4: watchdog with arready held off for 20 cycles, DECERR forwarded
        ar_wait = 20; r_resp_k = 2'd3; r_data_k = 32'hA5A50001;
        exp_q.push_back(rsp_word(1'b0, 2'd3, 32'hA5A50001));
        push_cmd(1'b0, 32'h40, 32'h0, 4'h0);
        wait_sig("t5_arvalid", 1);
        repeat (6) @(negedge aclk);
        check_val("t5_tmo_before", 64'(timeout), 64'd0);
        @(negedge aclk);
        check_val("t5_tmo_set", 64'(timeout), 64'd1);
        check_val("t5_no_abort", 64'(arvalid), 64'd1);
        wait_drain("t5_drain");
        check_val("t5_tmo_sticky", 64'(timeout), 64'd1);
        ar_wait = 0; r_resp_k = 2'd0;

        // T5: five commands against a stalled slave, then in-order drain
        stall = 1'b1; r_from_adr = 1'b1;
        exp_q.push_back(rsp_word(1'b1, 2'd0, 32'h0));
        exp_q.push_back(rsp_word(1'b0, 2'd0, 32'hC0DE0104));
        exp_q.push_back(rsp_word(1'b1, 2'd0, 32'h0));
        exp_q.push_back(rsp_word(1'b0, 2'd0, 32'hC0DE010C));
        exp_q.push_back(rsp_word(1'b1, 2'd0, 32'h0));
        push_cmd(1'b1, 32'h100, 32'h11111111, 4'hF);
        push_cmd(1'b0, 32'h104, 32'h0, 4'h0);
        push_cmd(1'b1, 32'h108, 32'h33333333, 4'hF);
        push_cmd(1'b0, 32'h10C, 32'h0, 4'h0);
        push_cmd(1'b1, 32'h110, 32'h55555555, 4'hF);
        check_val("t3_full_ready", 64'(cmd_ready), 64'd0);
        check_val("t3_full_count", 64'(cmd_count), 64'd4);
        check_val("t3_busy", 64'(busy), 64'd1);
        repeat (5) @(negedge aclk);
        check_val("t3_hold_aw", 64'(awvalid), 64'd1);
        check_val("t3_hold_addr", 64'(awaddr), 64'h100);
        check_val("t3_hold_count", 64'(cmd_count), 64'd4);
        stall = 1'b0;
        wait_drain("t3_drain");
        check_val("t3_empty", 64'(cmd_count), 64'd0);
        r_from_adr = 1'b0;

        // T6: reset while waiting for BRESP with two commands queued
        b_wait = 50;
        push_cmd(1'b1, 32'h200, 32'hA0000000, 4'hF);
        push_cmd(1'b1, 32'h204, 32'hA0000001, 4'hF);
        push_cmd(1'b1, 32'h208, 32'hA0000002, 4'hF);
        wait_sig("t6_bready", 2);
        check_val("t6_state", 64'(fsm_state), 64'(WR_RESP));
        check_val("t6_queued", 64'(cmd_count), 64'd2);
        areset = 1'b1;
        @(negedge aclk);
        check_val("t6_valids", {58'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 64'd0);
        check_val("t6_count", 64'(cmd_count), 64'd0);
        check_val("t6_tmo_busy", {62'd0, timeout, busy}, 64'd0);
        check_val("t6_state_idle", 64'(fsm_state), 64'(IDLE));
        areset = 1'b0; b_wait = 0;
        @(negedge aclk);

        // recovery after reset
        exp_q.push_back(rsp_word(1'b1, 2'd0, 32'h0));
        push_cmd(1'b1, 32'h300, 32'hCAFEF00D, 4'hF);
        wait_drain("t6_recover_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
